msd_pipe_adder: RTL and testbench

Parametrised, flow-controlled successor to the three-step MSD (modified signed-digit) carry-free adder used in the four-valued multiplier datapath.
- Accepts two P-digit MSD operands plus an opcode (add, subtract, negated add) and a tag.
- Runs the T/W → T'/W' → T transform chain over three registered stages with valid/ready backpressure.
- Emits a (P+2)-digit MSD result. Used to reduce partial-product rows and as a standalone MSD ALU in later multiplier generations.

---
 rtl/msd_pkg.sv | 78 +++++++
 rtl/msd_pipe_reg.sv | 36 +++
 rtl/msd_pipe_adder.sv | 171 +++++++++++++++++
 tb/tb_msd_pipe_adder.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msd_pkg.sv
// Shared definitions for the MSD (modified signed-digit) pipelined adder:
// digit codes, opcodes and the per-digit transform rules used by each stage.
package msd_pkg;

    // Two-bit digit codes; code 10 never comes out of the adder and reads as 0
    localparam logic [1:0] MSD_ZERO = 2'b00;
    localparam logic [1:0] MSD_POS  = 2'b01;
    localparam logic [1:0] MSD_NEG  = 2'b11;
    localparam logic [1:0] MSD_ILL  = 2'b10;

    // Opcodes; code 11 behaves as an add
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NEG = 2'b10;

    // Swap +1 and -1; zero and the illegal code both become zero
    function automatic logic [1:0] msd_negate(input logic [1:0] d);
        case (d)
            MSD_POS: return MSD_NEG;
            MSD_NEG: return MSD_POS;
            default: return MSD_ZERO;
        endcase
    endfunction

    // Digit as a small signed number for in-stage digit sums
    function automatic logic signed [2:0] msd_val(input logic [1:0] d);
        case (d)
            MSD_POS: return 3'sb001;
            MSD_NEG: return 3'sb111;
            default: return 3'sb000;
        endcase
    endfunction

    // Encode a digit sum known to lie in {-1,0,+1}
    function automatic logic [1:0] msd_from_val(input logic signed [2:0] s);
        case (s)
            3'sb001: return MSD_POS;
            3'sb111: return MSD_NEG;
            default: return MSD_ZERO;
        endcase
    endfunction

    // First transform: s = 2T + W; a +-1 sum pushes the transfer outward and
    // leaves an opposite-signed weight digit, which is what lets the second
    // transform avoid same-sign collisions.
    function automatic logic [3:0] msd_step1(input logic signed [2:0] s);
        case (s)
            3'sb010: return {MSD_POS,  MSD_ZERO};
            3'sb001: return {MSD_POS,  MSD_NEG};
            3'sb111: return {MSD_NEG,  MSD_POS};
            3'sb110: return {MSD_NEG,  MSD_ZERO};
            default: return {MSD_ZERO, MSD_ZERO};
        endcase
    endfunction

    // Second transform: only a +-2 sum produces a transfer, +-1 stays in place.
    // A +2 needs W=+1, i.e. T=-1 from the digit below in step 1, so the
    // neighbour above cannot also hold a +1 weight (and symmetrically for -2).
    function automatic logic [3:0] msd_step2(input logic signed [2:0] s);
        case (s)
            3'sb010: return {MSD_POS,  MSD_ZERO};
            3'sb001: return {MSD_ZERO, MSD_POS};
            3'sb111: return {MSD_ZERO, MSD_NEG};
            3'sb110: return {MSD_NEG,  MSD_ZERO};
            default: return {MSD_ZERO, MSD_ZERO};
        endcase
    endfunction

    // Integer value of one digit, for models and debug
    function automatic int msd_to_int(input logic [1:0] d);
        case (d)
            MSD_POS: return 1;
            MSD_NEG: return -1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/msd_pipe_reg.sv
// Valid/ready register slice: one entry, loads whenever it is empty or its
// current content leaves this cycle, so a chain of these runs bubble-free.
module msd_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    assign up_ready = !valid_reg || dn_ready;
    assign dn_valid = valid_reg;
    assign dn_data  = data_reg;

    // Take new content when there is room; data only changes on a real load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (up_ready) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg <= up_data;
            end
        end
    end

endmodule

// File: rtl/msd_pipe_adder.sv
// Three-stage flow-controlled MSD carry-free adder/subtractor.
// Stage 1 registers T(shifted)/W, stage 2 registers T'(shifted)/W',
// stage 3 registers the final digit-wise sum (negated for OP_NEG).
// Build option: define MSD_DIGIT_CHECK_EN to flag illegal (10) input digits
// on err; otherwise err is tied low and no check logic exists.
module msd_pipe_adder #(
    parameter int P     = 33,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*P-1:0]   in_a,
    input  logic [2*P-1:0]   in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*P+3:0]   out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic             err
);
    import msd_pkg::*;

    localparam int N1   = P + 1;
    localparam int N2   = P + 2;
    localparam int S1_W = 2 + TAG_W + 4*N1;
    localparam int S2_W = 2 + TAG_W + 4*N2;
    localparam int S3_W = TAG_W + 2*N2;

    genvar gi;

    // ---------------- stage 1: operand conditioning and T/W split ----------
    logic [1:0]      op_eff;
    logic [2*P-1:0]  b_eff;
    logic [2*N1-1:0] t1_sh;
    logic [2*N1-1:0] w1;
    logic [S1_W-1:0] s1_in;

    assign op_eff = (in_op == 2'b11) ? OP_ADD : in_op;

    for (gi = 0; gi < P; gi++) begin : g_s1
        logic [3:0] tw;
        assign b_eff[2*gi +: 2]   = (op_eff == OP_SUB) ? msd_negate(in_b[2*gi +: 2])
                                                       : in_b[2*gi +: 2];
        assign tw                 = msd_step1(msd_val(in_a[2*gi +: 2]) + msd_val(b_eff[2*gi +: 2]));
        assign t1_sh[2*gi+2 +: 2] = tw[3:2];
        assign w1[2*gi +: 2]      = tw[1:0];
    end
    assign t1_sh[1:0]     = MSD_ZERO;
    assign w1[2*P +: 2]   = MSD_ZERO;
    assign s1_in          = {op_eff, in_tag, t1_sh, w1};

    logic            s1_valid;
    logic [S1_W-1:0] s1_data;
    logic            s2_ready;

    msd_pipe_reg #(.W(S1_W)) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (s1_in),
        .dn_valid (s1_valid),
        .dn_ready (s2_ready),
        .dn_data  (s1_data)
    );

    // ---------------- stage 2: T'/W' transform --------------------------------
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [2*N1-1:0]  s1_t;
    logic [2*N1-1:0]  s1_w;
    logic [2*N2-1:0]  t2_sh;
    logic [2*N2-1:0]  w2;
    logic [S2_W-1:0]  s2_in;

    assign s1_op  = s1_data[S1_W-1 -: 2];
    assign s1_tag = s1_data[S1_W-3 -: TAG_W];
    assign s1_t   = s1_data[4*N1-1 : 2*N1];
    assign s1_w   = s1_data[2*N1-1 : 0];

    for (gi = 0; gi < N1; gi++) begin : g_s2
        logic [3:0] tw;
        assign tw                 = msd_step2(msd_val(s1_t[2*gi +: 2]) + msd_val(s1_w[2*gi +: 2]));
        assign t2_sh[2*gi+2 +: 2] = tw[3:2];
        assign w2[2*gi +: 2]      = tw[1:0];
    end
    assign t2_sh[1:0]     = MSD_ZERO;
    assign w2[2*N1 +: 2]  = MSD_ZERO;
    assign s2_in          = {s1_op, s1_tag, t2_sh, w2};

    logic            s2_valid;
    logic [S2_W-1:0] s2_data;
    logic            s3_ready;

    msd_pipe_reg #(.W(S2_W)) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (s1_valid),
        .up_ready (s2_ready),
        .up_data  (s2_in),
        .dn_valid (s2_valid),
        .dn_ready (s3_ready),
        .dn_data  (s2_data)
    );

    // ---------------- stage 3: final digit-wise sum, optional negate --------
    logic [1:0]       s2_op;
    logic [TAG_W-1:0] s2_tag;
    logic [2*N2-1:0]  s2_t;
    logic [2*N2-1:0]  s2_w;
    logic [2*N2-1:0]  sum3;
    logic [S3_W-1:0]  s3_in;

    assign s2_op  = s2_data[S2_W-1 -: 2];
    assign s2_tag = s2_data[S2_W-3 -: TAG_W];
    assign s2_t   = s2_data[4*N2-1 : 2*N2];
    assign s2_w   = s2_data[2*N2-1 : 0];

    // No same-sign pair reaches here, so every digit sum fits one digit
    for (gi = 0; gi < N2; gi++) begin : g_s3
        logic [1:0] d;
        assign d                = msd_from_val(msd_val(s2_t[2*gi +: 2]) + msd_val(s2_w[2*gi +: 2]));
        assign sum3[2*gi +: 2]  = (s2_op == OP_NEG) ? msd_negate(d) : d;
    end
    assign s3_in = {s2_tag, sum3};

    logic [S3_W-1:0] s3_data;

    msd_pipe_reg #(.W(S3_W)) u_s3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (s2_valid),
        .up_ready (s3_ready),
        .up_data  (s3_in),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s3_data)
    );

    assign out_sum = s3_data[2*N2-1 : 0];
    assign out_tag = s3_data[S3_W-1 -: TAG_W];

    // ---------------- illegal-digit flag --------------------------------------
`ifdef MSD_DIGIT_CHECK_EN
    logic [P-1:0] ill_a;
    logic [P-1:0] ill_b;
    logic         err_reg;

    for (gi = 0; gi < P; gi++) begin : g_ill
        assign ill_a[gi] = (in_a[2*gi +: 2] == MSD_ILL);
        assign ill_b[gi] = (in_b[2*gi +: 2] == MSD_ILL);
    end

    // Remember any illegal digit on an accepted operand until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (in_valid && in_ready && ((|ill_a) || (|ill_b))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_msd_pipe_adder.sv
// Self-checking bench for msd_pipe_adder: results are judged by numeric
// value (weighted digit sum) and digit legality against an integer model.
module tb_msd_pipe_adder;
    import msd_pkg::*;

    localparam int P     = 33;
    localparam int TAG_W = 4;
    localparam int AW    = 2*P;
    localparam int OW    = 2*P + 4;
`ifdef MSD_DIGIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_a;
    logic [AW-1:0]    in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_sum;
    logic [TAG_W-1:0] out_tag;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        longint           val;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t exp_q[$];

    msd_pipe_adder #(.P(P), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model -----------------------------------------
    function automatic longint opnd_value(input logic [AW-1:0] v);
        longint acc = 0;
        for (int i = 0; i < P; i++) acc += longint'(msd_to_int(v[2*i +: 2])) * (longint'(1) << i);
        return acc;
    endfunction

    function automatic longint sum_value(input logic [OW-1:0] v);
        longint acc = 0;
        for (int i = 0; i < P + 2; i++) acc += longint'(msd_to_int(v[2*i +: 2])) * (longint'(1) << i);
        return acc;
    endfunction

    function automatic int ill_count(input logic [OW-1:0] v);
        int n = 0;
        for (int i = 0; i < P + 2; i++) if (v[2*i +: 2] == MSD_ILL) n++;
        return n;
    endfunction

    function automatic longint ref_result(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                          input logic [1:0] op);
        longint x = opnd_value(a);
        longint y = opnd_value(b);
        case (op)
            OP_SUB:  return x - y;
            OP_NEG:  return -(x + y);
            default: return x + y;
        endcase
    endfunction

    function automatic logic [AW-1:0] rand_operand();
        logic [AW-1:0] v = '0;
        for (int i = 0; i < P; i++) begin
            case ($urandom_range(0, 2))
                0:       v[2*i +: 2] = MSD_ZERO;
                1:       v[2*i +: 2] = MSD_POS;
                default: v[2*i +: 2] = MSD_NEG;
            endcase
        end
        return v;
    endfunction

    // ---------------- stimulus helpers (no checking) --------------------------
    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [1:0] op, input logic [TAG_W-1:0] tag, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tag;
        out_ready = ordy;
    endtask

    // Send one op into an empty pipe and wait for its result; lat counts clock
    // edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic run_single(input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [1:0] op, input logic [TAG_W-1:0] tag,
                              output logic [OW-1:0] sum, output logic [TAG_W-1:0] otag,
                              output int lat);
        int guard = 0;
        @(negedge clk);
        drive(1'b1, a, b, op, tag, 1'b1);
        #1;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sum  = out_sum;
        otag = out_tag;
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b1);
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        vectors++;
        if (out_sum !== '0) begin miscompares++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
        vectors++;
        if (out_tag !== '0) begin miscompares++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b want 0", err); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        rst_n = 1'b1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_directed();
        logic [AW-1:0]    ta[5];
        logic [AW-1:0]    tb[5];
        logic [1:0]       top[5];
        logic [TAG_W-1:0] ttag[5];
        longint           texp[5];
        logic [OW-1:0]    sum;
        logic [TAG_W-1:0] otag;
        int               lat;
        // +5 = (0,+1,0,+1), +3 = (0,0,+1,+1), +7 = (+1,0,0,-1), -15 = all -1, -7 = (-1,0,+1,-1)
        ta[0] = AW'(8'b00_01_00_01); tb[0] = AW'(8'b00_00_01_01); top[0] = OP_ADD; ttag[0] = 4'd3;  texp[0] = 8;
        ta[1] = AW'(8'b00_01_00_01); tb[1] = AW'(8'b01_00_00_11); top[1] = OP_SUB; ttag[1] = 4'd5;  texp[1] = -2;
        ta[2] = AW'(8'b00_01_00_01); tb[2] = AW'(8'b00_00_01_01); top[2] = OP_NEG; ttag[2] = 4'd9;  texp[2] = -8;
        ta[3] = AW'(8'b00_01_00_01); tb[3] = AW'(8'b00_00_01_01); top[3] = 2'b11;  ttag[3] = 4'd12; texp[3] = 8;
        ta[4] = AW'(8'b11_11_11_11); tb[4] = AW'(8'b11_00_01_11); top[4] = OP_SUB; ttag[4] = 4'd6;  texp[4] = -8;
        for (int k = 0; k < 5; k++) begin
            run_single(ta[k], tb[k], top[k], ttag[k], sum, otag, lat);
            $display("directed %0d: op=%0d tag=%0d -> value %0d tag %0d latency %0d",
                     k, top[k], ttag[k], sum_value(sum), otag, lat);
            vectors++;
            if (lat !== 3) begin miscompares++; $display("FAIL directed_latency[%0d]: got %0d want 3", k, lat); end
            vectors++;
            if (sum_value(sum) !== texp[k]) begin miscompares++; $display("FAIL directed_value[%0d]: got %0d want %0d", k, sum_value(sum), texp[k]); end
            vectors++;
            if (otag !== ttag[k]) begin miscompares++; $display("FAIL directed_tag[%0d]: got %0d want %0d", k, otag, ttag[k]); end
            vectors++;
            if (ill_count(sum) !== 0) begin miscompares++; $display("FAIL directed_digits[%0d]: got %0d illegal digits want 0", k, ill_count(sum)); end
        end
    endtask

    task automatic test_extremes();
        logic [AW-1:0]    pos_all;
        logic [AW-1:0]    neg_all;
        logic [AW-1:0]    ta[5];
        logic [AW-1:0]    tb[5];
        logic [1:0]       top[5];
        longint           texp[5];
        longint           big;
        logic [OW-1:0]    sum;
        logic [TAG_W-1:0] otag;
        int               lat;
        for (int i = 0; i < P; i++) begin
            pos_all[2*i +: 2] = MSD_POS;
            neg_all[2*i +: 2] = MSD_NEG;
        end
        big = (longint'(1) << (P + 1)) - 2;
        ta[0] = pos_all; tb[0] = pos_all; top[0] = OP_ADD; texp[0] = big;
        ta[1] = neg_all; tb[1] = neg_all; top[1] = OP_ADD; texp[1] = -big;
        ta[2] = pos_all; tb[2] = neg_all; top[2] = OP_ADD; texp[2] = 0;
        ta[3] = pos_all; tb[3] = neg_all; top[3] = OP_SUB; texp[3] = big;
        ta[4] = neg_all; tb[4] = neg_all; top[4] = OP_NEG; texp[4] = big;
        for (int k = 0; k < 5; k++) begin
            run_single(ta[k], tb[k], top[k], TAG_W'(k + 1), sum, otag, lat);
            $display("extreme %0d: op=%0d -> value %0d", k, top[k], sum_value(sum));
            vectors++;
            if (sum_value(sum) !== texp[k]) begin miscompares++; $display("FAIL extreme_value[%0d]: got %0d want %0d", k, sum_value(sum), texp[k]); end
            vectors++;
            if (ill_count(sum) !== 0) begin miscompares++; $display("FAIL extreme_digits[%0d]: got %0d illegal digits want 0", k, ill_count(sum)); end
            vectors++;
            if (otag !== TAG_W'(k + 1)) begin miscompares++; $display("FAIL extreme_tag[%0d]: got %0d want %0d", k, otag, k + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int               sent = 0;
        int               got = 0;
        int               first_c = -1;
        int               last_c = -1;
        logic [AW-1:0]    a;
        logic [AW-1:0]    b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        exp_t             e;
        exp_q.delete();
        for (int c = 0; c < 80 && got < 20; c++) begin
            @(negedge clk);
            if (sent < 20) begin
                a = rand_operand(); b = rand_operand();
                op = 2'($urandom_range(0, 3)); tag = TAG_W'(sent);
                drive(1'b1, a, b, op, tag, 1'b1);
            end else begin
                drive(1'b0, '0, '0, OP_ADD, '0, 1'b1);
            end
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b2b_spurious: got result value %0d with nothing outstanding", sum_value(out_sum));
                end else begin
                    e = exp_q.pop_front();
                    $display("b2b result %0d: value %0d tag %0d (want %0d tag %0d)", got, sum_value(out_sum), out_tag, e.val, e.tag);
                    vectors++;
                    if (sum_value(out_sum) !== e.val) begin miscompares++; $display("FAIL b2b_value[%0d]: got %0d want %0d", got, sum_value(out_sum), e.val); end
                    vectors++;
                    if (out_tag !== e.tag) begin miscompares++; $display("FAIL b2b_tag[%0d]: got %0d want %0d", got, out_tag, e.tag); end
                    vectors++;
                    if (ill_count(out_sum) !== 0) begin miscompares++; $display("FAIL b2b_digits[%0d]: got %0d illegal digits want 0", got, ill_count(out_sum)); end
                end
                got++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (in_valid) begin
                vectors++;
                if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready: got %0b want 1 at cycle %0d", in_ready, c); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{ref_result(a, b, op), tag});
                sent++;
            end
        end
        vectors++;
        if (got !== 20) begin miscompares++; $display("FAIL b2b_count: got %0d results want 20", got); end
        vectors++;
        if (last_c - first_c !== 19) begin miscompares++; $display("FAIL b2b_throughput: got span %0d cycles want 19", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        int               sent = 0;
        int               got = 0;
        int               stall_acc = 0;
        bit               held = 0;
        logic             ordy;
        logic             exp_rdy;
        logic [OW-1:0]    held_sum;
        logic [TAG_W-1:0] held_tag;
        logic [AW-1:0]    a;
        logic [AW-1:0]    b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        exp_t             e;
        exp_q.delete();
        for (int c = 0; c < 100 && got < 12; c++) begin
            @(negedge clk);
            ordy = (c >= 6);
            if (sent < 12) begin
                a = rand_operand(); b = rand_operand();
                op = 2'($urandom_range(0, 3)); tag = TAG_W'(sent + 4);
                drive(1'b1, a, b, op, tag, ordy);
            end else begin
                drive(1'b0, '0, '0, OP_ADD, '0, ordy);
            end
            #1;
            // ready is low only when three ops are in flight and the output is blocked
            exp_rdy = !(exp_q.size() == 3 && !ordy);
            vectors++;
            if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL bp_in_ready: got %0b want %0b at cycle %0d", in_ready, exp_rdy, c); end
            if (out_valid && !ordy) begin
                if (held) begin
                    vectors++;
                    if (out_sum !== held_sum || out_tag !== held_tag) begin
                        miscompares++;
                        $display("FAIL bp_hold: got %h/%0d want %h/%0d at cycle %0d", out_sum, out_tag, held_sum, held_tag, c);
                    end
                end else begin
                    held = 1; held_sum = out_sum; held_tag = out_tag;
                end
            end else begin
                held = 0;
            end
            if (out_valid && ordy) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL bp_spurious: got result value %0d with nothing outstanding", sum_value(out_sum));
                end else begin
                    e = exp_q.pop_front();
                    $display("bp result %0d: value %0d tag %0d (want %0d tag %0d)", got, sum_value(out_sum), out_tag, e.val, e.tag);
                    vectors++;
                    if (sum_value(out_sum) !== e.val) begin miscompares++; $display("FAIL bp_value[%0d]: got %0d want %0d", got, sum_value(out_sum), e.val); end
                    vectors++;
                    if (out_tag !== e.tag) begin miscompares++; $display("FAIL bp_tag[%0d]: got %0d want %0d", got, out_tag, e.tag); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{ref_result(a, b, op), tag});
                sent++;
                if (!ordy) stall_acc++;
            end
        end
        vectors++;
        if (got !== 12) begin miscompares++; $display("FAIL bp_count: got %0d results want 12", got); end
        vectors++;
        if (stall_acc !== 3) begin miscompares++; $display("FAIL bp_stall_accepts: got %0d want 3", stall_acc); end
        vectors++;
        if (exp_q.size() !== 0) begin miscompares++; $display("FAIL bp_leftover: got %0d outstanding want 0", exp_q.size()); end
    endtask

    task automatic test_digit_check();
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        int            lat = 0;
        // digits (+1, ILL, +1) read as +5; plus +3 gives +8
        a = AW'(8'b00_01_10_01);
        b = AW'(8'b00_00_01_01);
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL digit_err_before: got %0b want 0", err); end
        drive(1'b1, a, b, OP_ADD, 4'd10, 1'b1);
        #1;
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b1);
        vectors++;
        if (err !== EXP_ERR) begin miscompares++; $display("FAIL digit_err_next: got %0b want %0b", err, EXP_ERR); end
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        $display("digit check: value %0d tag %0d err %0b", sum_value(out_sum), out_tag, err);
        vectors++;
        if (sum_value(out_sum) !== 64'sd8) begin miscompares++; $display("FAIL digit_value: got %0d want 8", sum_value(out_sum)); end
        vectors++;
        if (out_tag !== 4'd10) begin miscompares++; $display("FAIL digit_tag: got %0d want 10", out_tag); end
        repeat (4) @(negedge clk);
        vectors++;
        if (err !== EXP_ERR) begin miscompares++; $display("FAIL digit_err_sticky: got %0b want %0b", err, EXP_ERR); end
    endtask

    task automatic test_midflight_reset();
        logic [AW-1:0]    a;
        logic [AW-1:0]    b;
        logic [OW-1:0]    sum;
        logic [TAG_W-1:0] otag;
        int               lat;
        @(negedge clk);
        drive(1'b1, rand_operand(), rand_operand(), OP_ADD, 4'd1, 1'b0);
        @(negedge clk);
        drive(1'b1, rand_operand(), rand_operand(), OP_SUB, 4'd2, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, OP_ADD, '0, 1'b0);
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_valid: got %0b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        $display("midflight reset: out_valid %0b out_sum %h out_tag %0d err %0b", out_valid, out_sum, out_tag, err);
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %0b want 0", out_valid); end
        vectors++;
        if (out_sum !== '0) begin miscompares++; $display("FAIL midrst_out_sum: got %h want 0", out_sum); end
        vectors++;
        if (out_tag !== '0) begin miscompares++; $display("FAIL midrst_out_tag: got %0d want 0", out_tag); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL midrst_err: got %0b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        a = rand_operand(); b = rand_operand();
        run_single(a, b, OP_NEG, 4'd7, sum, otag, lat);
        $display("after reset: value %0d tag %0d latency %0d", sum_value(sum), otag, lat);
        vectors++;
        if (otag !== 4'd7) begin miscompares++; $display("FAIL midrst_first_tag: got %0d want 7", otag); end
        vectors++;
        if (sum_value(sum) !== ref_result(a, b, OP_NEG)) begin miscompares++; $display("FAIL midrst_first_value: got %0d want %0d", sum_value(sum), ref_result(a, b, OP_NEG)); end
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL midrst_latency: got %0d want 3", lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_extremes();
        test_back_to_back();
        test_backpressure();
        test_digit_check();
        test_midflight_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
